// File: rtl/edge_sync_stage.sv
// Multi-flop synchroniser for a vector of independent lanes.
// All stages clear to 0 on asynchronous active-low reset. Only instantiated
// when at least one stage is wanted; the zero-stage bypass lives in the top.
module edge_sync_stage #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // Shift chain: stage 0 captures the raw input, each later stage copies its predecessor
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int k = 1; k < STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/falling_edge_detector.sv
// Vectorised synchronous falling-edge detector.
// Each lane registers a one-cycle Detect pulse when its sampled input goes
// 1 -> 0 between consecutive rising clock edges, and keeps a saturating
// count of those pulses. Detect is always a flop output, never a function
// of D through combinational logic.
// Interface contract: there is no handshake; Detect is a free-running
// event strobe valid for exactly one clk cycle per sampled falling edge,
// and edge_count is updated on the same edge so the two are always coherent.
// SYNC_STAGES is legal in 0..3; 0 means D is already synchronous to clk.
module falling_edge_detector #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 0,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       D,
  output logic [WIDTH-1:0]       Detect,
  output logic [WIDTH*CNT_W-1:0] edge_count,
  input  logic                   count_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0]             w_s;
  logic [WIDTH-1:0]             w_fall;
  logic [WIDTH-1:0]             r_d_q;
  logic [WIDTH-1:0]             r_detect;
  logic [WIDTH-1:0][CNT_W-1:0]  r_count;

  // Sampling path: optional synchroniser ahead of the history register
  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign w_s = D;
    end else begin : g_sync
      edge_sync_stage #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
      ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (D),
        .o_q (w_s)
      );
    end
  endgenerate

  // A fall is "previous sample high, current sample low"; history resets to 0
  // so holding D low through reset release never produces a pulse.
  assign w_fall = r_d_q & ~w_s;

  // History and Detect registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_q    <= '0;
      r_detect <= '0;
    end else begin
      r_d_q    <= w_s;
      r_detect <= w_fall;
    end
  end

  // Per-lane saturating event counters; clear wins over a same-edge increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (count_clr) begin
      r_count <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_fall[i] && (r_count[i] != CNT_MAX)) begin
          r_count[i] <= r_count[i] + CNT_ONE;
        end
      end
    end
  end

  assign Detect     = r_detect;
  assign edge_count = r_count;

endmodule

// File: tb/tb_falling_edge_detector.sv
// Bench for falling_edge_detector. Four instances cover the configurations of
// interest: A (W=1,S=0,C=8), B (W=1,S=0,C=2), C (W=2,S=0,C=8), D (W=1,S=2,C=8).
// Lanes are numbered 0:A, 1:B, 2:C[0], 3:C[1], 4:D.
module tb_falling_edge_detector;

  localparam int NL = 5;
  localparam int EW = NL + NL*8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       count_clr;
  logic       d_a, d_b, d_d;
  logic [1:0] d_c;
  logic       det_a, det_b, det_d;
  logic [1:0] det_c;
  logic [7:0] cnt_a, cnt_d;
  logic [1:0] cnt_b;
  logic [15:0] cnt_c;

  falling_edge_detector #(.WIDTH(1), .SYNC_STAGES(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .D(d_a), .Detect(det_a), .edge_count(cnt_a), .count_clr(count_clr));
  falling_edge_detector #(.WIDTH(1), .SYNC_STAGES(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .D(d_b), .Detect(det_b), .edge_count(cnt_b), .count_clr(count_clr));
  falling_edge_detector #(.WIDTH(2), .SYNC_STAGES(0), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .D(d_c), .Detect(det_c), .edge_count(cnt_c), .count_clr(count_clr));
  falling_edge_detector #(.WIDTH(1), .SYNC_STAGES(2), .CNT_W(8)) dut_d (
    .clk(clk), .rst(rst), .D(d_d), .Detect(det_d), .edge_count(cnt_d), .count_clr(count_clr));

  // ---------------- reference model state ----------------
  logic [NL-1:0] hist[$];        // value driven ahead of each clock edge since reset release
  int            cnt_m[NL];
  logic [EW-1:0] exp_q[$];
  int            tests = 0;
  int            fails = 0;

  function automatic int lane_delay(input int lane);
    return (lane == 4) ? 2 : 0;
  endfunction

  function automatic int lane_max(input int lane);
    return (lane == 1) ? 3 : 255;
  endfunction

  // Sampled value of a lane 'back' edges before the newest edge; anything
  // before reset release (or still inside the synchroniser) reads as 0.
  function automatic logic sampled(input int lane, input int back);
    int idx;
    idx = hist.size() - 1 - back - lane_delay(lane);
    if (idx < 0) return 1'b0;
    return hist[idx][lane];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < NL; j++) cnt_m[j] = 0;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle on the falling edge and pushes what the next rising edge must show.
  task automatic drive_cycle(input logic [NL-1:0] v, input logic clr, input logic rst_v);
    logic [EW-1:0] e;
    logic          det;
    @(negedge clk);
    rst       = rst_v;
    count_clr = clr;
    d_a       = v[0];
    d_b       = v[1];
    d_c       = v[3:2];
    d_d       = v[4];
    e = '0;
    if (!rst_v) begin
      model_reset();
    end else begin
      hist.push_back(v);
      for (int j = 0; j < NL; j++) begin
        det = sampled(j, 1) & ~sampled(j, 0);
        e[j] = det;
        if (clr) cnt_m[j] = 0;
        else if (det && cnt_m[j] < lane_max(j)) cnt_m[j] = cnt_m[j] + 1;
      end
    end
    for (int j = 0; j < NL; j++) e[NL + 8*j +: 8] = 8'(cnt_m[j]);
    exp_q.push_back(e);
  endtask

  // Reset asserted mid-cycle right after a Detect pulse has been registered.
  task automatic async_reset_check();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_detect", int'(det_a), 0);
    check("async_rst_count", int'(cnt_a), 0);
    check("async_rst_detect_w2", int'(det_c), 0);
    model_reset();
  endtask

  // ---------------- monitor / scoreboard ----------------
  function automatic int act_cnt(input int lane);
    case (lane)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      2:       return int'(cnt_c[7:0]);
      3:       return int'(cnt_c[15:8]);
      default: return int'(cnt_d);
    endcase
  endfunction

  initial begin
    logic [EW-1:0] e;
    logic [NL-1:0] act_det;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_det = {det_d, det_c, det_b, det_a};
        for (int j = 0; j < NL; j++) begin
          check($sformatf("detect_lane%0d", j), int'(act_det[j]), int'(e[j]));
          check($sformatf("count_lane%0d", j), act_cnt(j), int'(e[NL + 8*j +: 8]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [NL-1:0] v;
    rst = 1'b0; count_clr = 1'b0;
    d_a = 1'b0; d_b = 1'b0; d_c = 2'b00; d_d = 1'b0;

    // reset one cycle, then D held low
    drive_cycle('0, 1'b0, 1'b0);
    repeat (5) drive_cycle('0, 1'b0, 1'b1);

    // single fall on every lane (both W=2 lanes together)
    repeat (2) drive_cycle('1, 1'b0, 1'b1);
    repeat (4) drive_cycle('0, 1'b0, 1'b1);

    // reset pulse while D high, then fall after release
    drive_cycle('1, 1'b0, 1'b1);
    drive_cycle('1, 1'b0, 1'b0);
    drive_cycle('1, 1'b0, 1'b1);
    repeat (4) drive_cycle('0, 1'b0, 1'b1);

    // assert reset while Detect is high
    repeat (2) drive_cycle('1, 1'b0, 1'b1);
    drive_cycle('0, 1'b0, 1'b1);
    async_reset_check();
    drive_cycle('0, 1'b0, 1'b0);
    repeat (2) drive_cycle('0, 1'b0, 1'b1);

    // rising edge only, then alternating train, then clear on a fall
    repeat (2) drive_cycle('1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) drive_cycle((i % 2 == 0) ? '0 : '1, 1'b0, 1'b1);
    repeat (3) drive_cycle('0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive_cycle((i % 2 == 0) ? '1 : '0, 1'b0, 1'b1);
    drive_cycle('1, 1'b0, 1'b1);
    drive_cycle('0, 1'b1, 1'b1);
    repeat (3) drive_cycle('0, 1'b0, 1'b1);

    // randomized traffic with sparse clears and resets
    for (int i = 0; i < 400; i++) begin
      v = NL'($urandom);
      drive_cycle(v, ($urandom_range(0, 24) == 0), ($urandom_range(0, 59) != 0));
    end
    repeat (4) drive_cycle('0, 1'b0, 1'b1);

    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/falling_edge_detector.md
Name: falling_edge_detector

Overview:
- Synchronous falling-edge detector: samples input D on every rising clock edge and emits a one-clock-wide registered pulse on Detect when D goes from 1 to 0 between consecutive samples.
- Vectorised over WIDTH independent lanes, with an optional input synchroniser for asynchronous sources.
- Includes a saturating falling-edge event counter per lane for debug and status.
- Sits at the boundary between raw control or strobe inputs and downstream FSMs that need single-cycle event pulses.

Parameters:
- WIDTH, 1, number of independent lanes on D and Detect.
- SYNC_STAGES, 0, number of flip-flop synchroniser stages ahead of detection (0 means D is already synchronous to clk; legal range 0..3).
- CNT_W, 8, width of each lane's saturating falling-edge counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- D  input  WIDTH  monitored signal(s).
- Detect  output  WIDTH  registered falling-edge pulse, one clk cycle per detected edge.
- edge_count  output  WIDTH*CNT_W  per-lane saturating count of detected falling edges; lane i occupies bits [i*CNT_W +: CNT_W].
- count_clr  input  1  synchronous clear of all edge_count lanes; active high.

Behaviour:
- Reset: while rst=0, the synchroniser flops, the history register d_q, Detect and edge_count are all 0. Reset is asynchronous and takes effect immediately, independent of clk.
- Sampling path: s = D delayed by SYNC_STAGES flops (s = D when SYNC_STAGES = 0). Each rising edge performs d_q <= s.
- Detection: on each rising edge, Detect[i] <= d_q[i] & ~s[i].
  - Detect is high for exactly one cycle per 1->0 transition of the sampled value.
  - Latency with SYNC_STAGES = 0: Detect rises at the first clock edge that samples D=0 after a sample of D=1. It falls at the next edge unless a new falling edge occurs.
  - Each synchroniser stage adds one cycle of latency.
- Rising edges (0->1) and steady levels produce Detect=0.
- Because history resets to 0, no spurious pulse occurs after reset deassertion while D is 0. If D is 1 at reset release, the first sampled 1->0 is detected.
- Reset mid-pulse: Detect clears immediately and history is lost. Any D fall that happens during reset is not reported.
- D toggling faster than clk: only sampled transitions count, with at most one pulse per clock. A 1-0-1 glitch between two clock edges is not detected.
- Counter:
  - When Detect[i] is set, edge_count lane i increments by 1 on the same edge Detect is registered, so the count is coherent with Detect.
  - Each lane saturates at 2^CNT_W-1 with no wrap.
  - count_clr=1 zeroes all lanes on the next edge and takes priority over a simultaneous increment.
- Lanes are fully independent, and simultaneous edges on multiple lanes are each reported.
- Detect is never driven combinationally from D.

Decomposition:
- No shared package; the parameters are local and there are no exported typedefs.
- One natural sub-module, edge_sync_stage, implementing a per-lane SYNC_STAGES-deep synchroniser with asynchronous active-low reset. It is instantiated once per lane or as a WIDTH-wide vector.
- Detection and counter logic live in the top module.

Test Plan:
- Config for all scenarios: clk period 10 ns, D changed on the falling clock edge, WIDTH=1, SYNC_STAGES=0.
- Reset then D held at 0: rst=0 for one cycle then 1; D=0 for 5 cycles -> Detect=0 throughout; edge_count=0.
- Single fall: D=1 for 2 cycles, then D=0 -> Detect=1 for exactly the one cycle after the first edge sampling 0, then 0; edge_count=1.
- Reset mid-operation: D=1, pulse rst=0 for one cycle, then D=0 after release -> Detect pulses once after the release; asserting rst while Detect=1 forces Detect=0 asynchronously, before the next clk edge.
- Rising edge and pulse train: D=0->1 -> no pulse. D alternating every cycle for 8 cycles -> 4 single-cycle Detect pulses, edge_count=4. Then count_clr=1 coinciding with a fall -> edge_count=0 on that edge.
- Saturation and lanes: CNT_W=2, 5 falls -> edge_count stays at 3. WIDTH=2 with both lanes falling on the same edge -> Detect=2'b11 for one cycle. SYNC_STAGES=2 -> pulse appears 2 cycles later than with SYNC_STAGES=0.
